// File: rtl/wb_decoder_if.sv
// ------------------------------------------------------------------
// wb_decoder_if : controller/PE-array bus bundle for wb_decoder
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

interface wb_decoder_if #(
  parameter int DATA_WID = 8,
  parameter int ICP_NUM  = 4,
  parameter int OCP_NUM  = 4,
  parameter int ADDR_B   = 4,
  parameter int ADDR_BUF = 8
);
  logic [1:0]                          pe_state;
  logic                                wrb;
  logic [ADDR_BUF-1:0]                 wrb_addr;
  logic [DATA_WID-1:0]                 wrb_data;
  logic [ADDR_B-1:0]                   rdb_addr;
  logic [OCP_NUM*ICP_NUM*DATA_WID-1:0] w_out;
  logic                                w_valid;
  logic [ADDR_B-1:0]                   w_addr;

  modport master (
    output pe_state, wrb, wrb_addr, wrb_data, rdb_addr,
    input  w_out, w_valid, w_addr
  );

  modport slave (
    input  pe_state, wrb, wrb_addr, wrb_data, rdb_addr,
    output w_out, w_valid, w_addr
  );
endinterface

`default_nettype wire

// File: rtl/wb_decoder.sv
// ------------------------------------------------------------------
// wb_decoder : flop weight buffer, single-word writes, registered block read
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_decoder #(
  parameter int DATA_WID = 8,
  parameter int ICP_NUM  = 4,
  parameter int OCP_NUM  = 4,
  parameter int ADDR_B   = 4,
  parameter int ADDR_BUF = 8
) (
  input  wire logic   clk,
  input  wire logic   reset,
  wb_decoder_if.slave bus
);

  localparam int DEPTH  = 2 ** ADDR_BUF;
  localparam int BLK    = OCP_NUM * ICP_NUM;
  localparam int LANE_W = ADDR_BUF - ADDR_B;
  localparam int OUT_W  = BLK * DATA_WID;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_VALID = 2'd1;
  localparam logic [1:0] c_ST_STALL = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  logic [DATA_WID-1:0] r_buf [0:DEPTH-1];
  logic [OUT_W-1:0]    r_w_out;
  logic [ADDR_B-1:0]   r_w_addr;
  logic                r_w_valid;

  logic [OUT_W-1:0]    w_rd_block;
  logic                w_is_valid;
  logic                w_wr_en;

  assign w_is_valid = (bus.pe_state == c_ST_VALID);
  assign w_wr_en    = w_is_valid & bus.wrb;

  // Lane k = o*ICP_NUM+i; its word address is the concatenation {block, k}.
  always_comb begin
    w_rd_block = '0;
    for (int k = 0; k < BLK; k++) begin
      w_rd_block[k*DATA_WID +: DATA_WID] = r_buf[{bus.rdb_addr, LANE_W'(k)}];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        r_buf[a] <= '0;
      end
    end else if (w_wr_en) begin
      r_buf[bus.wrb_addr] <= bus.wrb_data;
    end
  end

  // Readout samples the pre-edge buffer, so a same-cycle write is seen next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w_out   <= '0;
      r_w_addr  <= '0;
      r_w_valid <= 1'b0;
    end else begin
      case (bus.pe_state)
        c_ST_VALID: begin
          r_w_out   <= w_rd_block;
          r_w_addr  <= bus.rdb_addr;
          r_w_valid <= 1'b1;
        end
        c_ST_STALL: begin
          r_w_out   <= r_w_out;
          r_w_addr  <= r_w_addr;
          r_w_valid <= r_w_valid;
        end
        c_ST_IDLE, c_ST_DONE: begin
          r_w_valid <= 1'b0;
        end
        default: begin
          r_w_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.w_out   = r_w_out;
  assign bus.w_addr  = r_w_addr;
  assign bus.w_valid = r_w_valid;

endmodule

`default_nettype wire

// File: tb/tb_wb_decoder.sv
// ------------------------------------------------------------------
// tb_wb_decoder : randomized bench for wb_decoder with a behavioural model
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_wb_decoder;

  logic clk;
  logic reset;

  wb_decoder_if #(.DATA_WID(8), .ICP_NUM(4), .OCP_NUM(4), .ADDR_B(4), .ADDR_BUF(8)) bus ();

  wb_decoder #(.DATA_WID(8), .ICP_NUM(4), .OCP_NUM(4), .ADDR_B(4), .ADDR_BUF(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0]   mem [0:255];
  logic [127:0] exp_out;
  logic [3:0]   exp_addr;
  logic         exp_valid;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 256; a++) mem[a] = 8'd0;
    exp_out   = '0;
    exp_addr  = '0;
    exp_valid = 1'b0;
  endtask

  // One clock: drive, take the edge, advance the model from the driven values.
  task automatic step(input int st, input bit wr, input int wa, input int wd, input int ra);
    bus.pe_state = 2'(st);
    bus.wrb      = wr;
    bus.wrb_addr = 8'(wa);
    bus.wrb_data = 8'(wd);
    bus.rdb_addr = 4'(ra);
    @(posedge clk);
    if (reset) begin
      if (st == 1) begin
        for (int o = 0; o < 4; o++)
          for (int i = 0; i < 4; i++)
            exp_out[(o*4+i)*8 +: 8] = mem[ra*16 + o*4 + i];
        exp_addr  = 4'(ra);
        exp_valid = 1'b1;
        if (wr) mem[wa] = 8'(wd);
      end else if (st != 2) begin
        exp_valid = 1'b0;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (bus.w_out !== exp_out || bus.w_addr !== exp_addr || bus.w_valid !== exp_valid) begin
        errors++;
        $display("FAIL cycle_cmp: got out=%h addr=%h valid=%b expected out=%h addr=%h valid=%b at %0t",
                 bus.w_out, bus.w_addr, bus.w_valid, exp_out, exp_addr, exp_valid, $time);
      end
    end
  end

  logic [127:0] lit;

  initial begin
    model_clear();
    reset = 1'b0;
    bus.pe_state = 2'd0;
    bus.wrb = 1'b0;
    bus.wrb_addr = '0;
    bus.wrb_data = '0;
    bus.rdb_addr = '0;
    #2;
    chk_en = 1'b1;

    // Reset held with toggling inputs
    for (int c = 0; c < 2; c++)
      step(1, 1'b1, $urandom_range(0, 255), $urandom_range(1, 255), $urandom_range(0, 15));
    check("rst_out", bus.w_out, 128'd0);
    check("rst_addr", {124'd0, bus.w_addr}, 128'd0);
    check("rst_valid", {127'd0, bus.w_valid}, 128'd0);
    reset = 1'b1;
    step(1, 1'b0, 0, 0, 0);
    check("rst_blk0", bus.w_out, 128'd0);

    // Single write/read, read-before-write
    step(1, 1'b1, 0, 2, 0);
    check("sw_valid", {127'd0, bus.w_valid}, 128'd1);
    check("sw_lane00_old", {120'd0, bus.w_out[7:0]}, 128'd0);
    step(1, 1'b0, 0, 0, 0);
    check("sw_lane00_new", bus.w_out, 128'd2);
    check("sw_addr", {124'd0, bus.w_addr}, 128'd0);

    // Lane mapping
    for (int k = 0; k < 256; k++)
      step(1, 1'b1, k, k + 1, $urandom_range(0, 15));
    step(1, 1'b0, 0, 0, 3);
    for (int k = 0; k < 16; k++) lit[k*8 +: 8] = 8'(48 + k + 1);
    check("map_blk3", bus.w_out, lit);
    check("map_addr", {124'd0, bus.w_addr}, 128'd3);
    check("map_lane32", {120'd0, bus.w_out[(3*4+2)*8 +: 8]}, 128'd63);

    // Gated write while IDLE
    step(0, 1'b1, 5, 8'hAA, 0);
    check("idle_valid", {127'd0, bus.w_valid}, 128'd0);
    step(1, 1'b0, 0, 0, 0);
    check("gated_lane11", {120'd0, bus.w_out[(1*4+1)*8 +: 8]}, 128'd6);

    // Stall holds
    step(1, 1'b0, 0, 0, 1);
    step(2, 1'b1, 20, 8'h55, 2);
    step(2, 1'b0, 0, 0, 2);
    for (int k = 0; k < 16; k++) lit[k*8 +: 8] = 8'(16 + k + 1);
    check("stall_out", bus.w_out, lit);
    check("stall_addr", {124'd0, bus.w_addr}, 128'd1);
    check("stall_valid", {127'd0, bus.w_valid}, 128'd1);

    // DONE drops valid
    step(3, 1'b1, 0, 1, 4);
    check("done_valid", {127'd0, bus.w_valid}, 128'd0);

    // Randomized traffic
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 15));

    // Asynchronous reset between edges
    for (int k = 0; k < 8; k++) step(1, 1'b1, 16 * 7 + k, 8'hC0 + k, 7);
    step(1, 1'b0, 0, 0, 7);
    #1;
    reset = 1'b0;
    #1;
    model_clear();
    check("arst_out", bus.w_out, 128'd0);
    check("arst_addr", {124'd0, bus.w_addr}, 128'd0);
    check("arst_valid", {127'd0, bus.w_valid}, 128'd0);
    step(1, 1'b1, 3, 9, 7);
    #2;
    reset = 1'b1;
    step(1, 1'b0, 0, 0, 7);
    check("post_rst_blk7", bus.w_out, 128'd0);
    check("post_rst_valid", {127'd0, bus.w_valid}, 128'd1);

    for (int c = 0; c < 200; c++)
      step($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 15));

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
